// File: rtl/ghostbus_pkg.sv
// Shared ghostbus host-side definitions: FSM state encoding and read-latency counter width.
package ghostbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam int unsigned RD_CNT_W = 4;

endpackage

// File: rtl/ghostbus_rr_arb2.sv
// Two-way round-robin grant; the most recently granted requester loses the next tie.
module ghostbus_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
    last_grant_d = last_grant_q;
    if (en && (|grant)) last_grant_d = grant[1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/ghostbus_host_arb.sv
// Shares the ghostbus host port between two masters, one transaction at a time,
// with single-cycle we/re strobes and fixed-latency read data return.
module ghostbus_host_arb
  import ghostbus_pkg::*;
#(
  parameter int AW       = 24,
  parameter int DW       = 32,
  parameter int RD_DELAY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ack,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ack,
  output logic [DW-1:0] req1_rdata,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_dout,
  output logic          gb_we,
  output logic          gb_re,
  input  logic [DW-1:0] gb_din
);

  state_e              state_q, state_d;
  logic [RD_CNT_W-1:0] cnt_q, cnt_d;
  logic                write_q, write_d;
  logic                id_q, id_d;
  logic [AW-1:0]       gb_addr_q, gb_addr_d;
  logic [DW-1:0]       gb_dout_q, gb_dout_d;
  logic                gb_we_q, gb_we_d;
  logic                gb_re_q, gb_re_d;
  logic [1:0]          ack_q, ack_d;
  logic [DW-1:0]       rdata0_q, rdata0_d;
  logic [DW-1:0]       rdata1_q, rdata1_d;

  logic [1:0] arb_req, grant;
  logic       arb_en;

  // Requests are only visible to the arbiter in IDLE, so held inputs are ignored mid-transaction.
  assign arb_req = (state_q == ST_IDLE) ? {req1_valid, req0_valid} : 2'b00;
  assign arb_en  = |grant;

  ghostbus_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (arb_req),
    .en    (arb_en),
    .grant (grant)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    id_d      = id_q;
    gb_addr_d = gb_addr_q;
    gb_dout_d = gb_dout_q;
    gb_we_d   = 1'b0;
    gb_re_d   = 1'b0;
    ack_d     = '0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          id_d      = grant[1];
          write_d   = grant[1] ? req1_write : req0_write;
          gb_addr_d = grant[1] ? req1_addr  : req0_addr;
          gb_dout_d = grant[1] ? req1_wdata : req0_wdata;
          gb_we_d   = write_d;
          gb_re_d   = ~write_d;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (write_q) begin
          ack_d[id_q] = 1'b1;
          state_d     = ST_ACK;
        end else begin
          cnt_d   = RD_CNT_W'(RD_DELAY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (id_q) rdata1_d = gb_din;
          else      rdata0_d = gb_din;
          ack_d[id_q] = 1'b1;
          state_d     = ST_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      id_q      <= 1'b0;
      gb_addr_q <= '0;
      gb_dout_q <= '0;
      gb_we_q   <= 1'b0;
      gb_re_q   <= 1'b0;
      ack_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      id_q      <= id_d;
      gb_addr_q <= gb_addr_d;
      gb_dout_q <= gb_dout_d;
      gb_we_q   <= gb_we_d;
      gb_re_q   <= gb_re_d;
      ack_q     <= ack_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign gb_addr    = gb_addr_q;
  assign gb_dout    = gb_dout_q;
  assign gb_we      = gb_we_q;
  assign gb_re      = gb_re_q;
  assign req0_ack   = ack_q[0];
  assign req1_ack   = ack_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_ghostbus_host_arb.sv
// Directed bench for ghostbus_host_arb with RD_DELAY=2; outputs sampled 1ns after each rising edge.
module tb_ghostbus_host_arb;

  localparam int AW = 24;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_write, req1_valid, req1_write;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_ack, req1_ack;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_dout;
  logic          gb_we, gb_re;
  logic [DW-1:0] gb_din;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ghostbus_host_arb #(.AW(AW), .DW(DW), .RD_DELAY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ack   (req0_ack),
    .req0_rdata (req0_rdata),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ack   (req1_ack),
    .req1_rdata (req1_rdata),
    .gb_addr    (gb_addr),
    .gb_dout    (gb_dout),
    .gb_we      (gb_we),
    .gb_re      (gb_re),
    .gb_din     (gb_din)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_excl();
    chk("strobe_excl", {31'd0, gb_we & gb_re}, 32'd0);
    chk("ack_excl", {31'd0, req0_ack & req1_ack}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    gb_din = '0;
    tick(); tick();
    chk("rst_we", {31'd0, gb_we}, 32'd0);
    chk("rst_re", {31'd0, gb_re}, 32'd0);
    chk("rst_addr", {8'd0, gb_addr}, 32'd0);
    chk("rst_dout", gb_dout, 32'd0);
    chk("rst_acks", {30'd0, req1_ack, req0_ack}, 32'd0);
    chk("rst_rdata0", req0_rdata, 32'd0);
    chk("rst_rdata1", req1_rdata, 32'd0);
    rst = 1'b0;

    // single write from req0; grant cycle G is the current IDLE cycle
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 24'h000010; req0_wdata = 32'h42;
    tick();
    chk("wr_we", {31'd0, gb_we}, 32'd1);
    chk("wr_re", {31'd0, gb_re}, 32'd0);
    chk("wr_addr", {8'd0, gb_addr}, 32'h10);
    chk("wr_dout", gb_dout, 32'h42);
    chk("wr_ack_early", {31'd0, req0_ack}, 32'd0);
    tick();
    chk("wr_ack", {31'd0, req0_ack}, 32'd1);
    chk("wr_we_off", {31'd0, gb_we}, 32'd0);
    req0_valid = 1'b0;
    tick();
    chk("wr_ack_once", {31'd0, req0_ack}, 32'd0);
    chk("wr_addr_hold", {8'd0, gb_addr}, 32'h10);

    // stale-data guard: req0 read, gb_din junk until T+2
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 24'h000020;
    tick();
    chk("st_re", {31'd0, gb_re}, 32'd1);
    chk("st_addr", {8'd0, gb_addr}, 32'h20);
    gb_din = 32'hFFFF;
    tick();
    chk("st_re_off", {31'd0, gb_re}, 32'd0);
    chk("st_noack", {31'd0, req0_ack}, 32'd0);
    tick();
    gb_din = 32'h1234;
    chk("st_noack2", {31'd0, req0_ack}, 32'd0);
    tick();
    gb_din = 32'hFFFF;
    chk("st_ack", {31'd0, req0_ack}, 32'd1);
    chk("st_rdata", req0_rdata, 32'h1234);
    chk("st_rdata1_untouched", req1_rdata, 32'd0);
    req0_valid = 1'b0;
    tick();
    chk("st_rdata_hold", req0_rdata, 32'h1234);

    // single read from req1 returning 0xA5
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 24'h000100;
    tick();
    chk("rd_re", {31'd0, gb_re}, 32'd1);
    chk("rd_we", {31'd0, gb_we}, 32'd0);
    chk("rd_addr", {8'd0, gb_addr}, 32'h100);
    gb_din = 32'h0;
    tick();
    tick();
    gb_din = 32'hA5;
    chk("rd_noack", {30'd0, req1_ack, req0_ack}, 32'd0);
    tick();
    gb_din = 32'h0;
    chk("rd_ack1", {31'd0, req1_ack}, 32'd1);
    chk("rd_ack0", {31'd0, req0_ack}, 32'd0);
    chk("rd_rdata", req1_rdata, 32'hA5);
    chk("rd_rdata0_hold", req0_rdata, 32'h1234);
    req1_valid = 1'b0;
    tick();
    chk("rd_ack_once", {31'd0, req1_ack}, 32'd0);

    // contention: both writes held for four transactions, order 0,1,0,1
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 24'h000030; req0_wdata = 32'h11;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 24'h000040; req1_wdata = 32'h22;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_excl();
      chk("ct_we", {31'd0, gb_we}, 32'd1);
      chk("ct_addr", {8'd0, gb_addr}, (i % 2 == 0) ? 32'h30 : 32'h40);
      chk("ct_dout", gb_dout, (i % 2 == 0) ? 32'h11 : 32'h22);
      tick();
      chk_excl();
      chk("ct_ack0", {31'd0, req0_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("ct_ack1", {31'd0, req1_ack}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      tick();
      chk("ct_idle_we", {31'd0, gb_we}, 32'd0);
    end
    chk("ct_addr_hold", {8'd0, gb_addr}, 32'h40);

    // reset during WAIT of a req0 read; last grant must return to favour req0
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 24'h000050;
    tick();
    chk("rs_re", {31'd0, gb_re}, 32'd1);
    tick();
    rst = 1'b1;
    req0_valid = 1'b0;
    gb_din = 32'h77;
    tick();
    rst = 1'b0;
    chk("rs_re_off", {31'd0, gb_re}, 32'd0);
    chk("rs_we_off", {31'd0, gb_we}, 32'd0);
    chk("rs_acks", {30'd0, req1_ack, req0_ack}, 32'd0);
    chk("rs_addr", {8'd0, gb_addr}, 32'd0);
    tick();
    chk("rs_noack_a", {30'd0, req1_ack, req0_ack}, 32'd0);
    chk("rs_rdata0", req0_rdata, 32'd0);
    tick();
    chk("rs_noack_b", {30'd0, req1_ack, req0_ack}, 32'd0);
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 24'h000060; req0_wdata = 32'h6;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 24'h000070; req1_wdata = 32'h7;
    tick();
    chk("rs_tie_addr", {8'd0, gb_addr}, 32'h60);
    chk("rs_tie_we", {31'd0, gb_we}, 32'd1);
    tick();
    chk("rs_tie_ack0", {31'd0, req0_ack}, 32'd1);
    chk("rs_tie_ack1", {31'd0, req1_ack}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // valid dropped right after grant: write still completes once
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 24'h000080; req0_wdata = 32'h99;
    tick();
    req0_valid = 1'b0; req0_addr = 24'h000FFF; req0_wdata = 32'hDEAD;
    chk("vd_we", {31'd0, gb_we}, 32'd1);
    chk("vd_addr", {8'd0, gb_addr}, 32'h80);
    chk("vd_dout", gb_dout, 32'h99);
    tick();
    chk("vd_ack", {31'd0, req0_ack}, 32'd1);
    chk("vd_addr_hold", {8'd0, gb_addr}, 32'h80);
    tick();
    chk("vd_ack_once", {31'd0, req0_ack}, 32'd0);
    tick();
    chk("vd_no_regrant", {30'd0, gb_re, gb_we}, 32'd0);
    chk("vd_no_ack", {31'd0, req0_ack}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
